// File: rtl/lifo_multi_ch.sv
// lifo_multi_ch: NUM_CH independent register-array stacks with one push port and one pop port.
// Optional registered error pulses are enabled by defining LIFO_ERR_FLAG_EN.
//------------------------------------------------------------------------------
// Module   : lifo_multi_ch
// Brief    : multi-channel LIFO with per-channel counts and same-channel bypass
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lifo_multi_ch #(
   parameter  int NUM_CH     = 4,
   parameter  int DEPTH      = 12,
   parameter  int DATA_WIDTH = 8,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   data_wr,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic                    rd_en,
   input  logic [CH_W-1:0]         rd_ch,
   output logic [DATA_WIDTH-1:0]   data_rd,
   output logic [NUM_CH-1:0]       lifo_full,
   output logic [NUM_CH-1:0]       lifo_empty,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic                    wr_err,
   output logic                    rd_err
);

   // Bit s is set when select value s names an existing channel.
   localparam int                CH_SPAN  = 1 << CH_W;
   localparam logic [CH_SPAN-1:0] CH_VALID = {CH_SPAN{1'b1}} >> (CH_SPAN - NUM_CH);

   logic [CNT_W-1:0]      sp_q     [NUM_CH];
   logic [CNT_W-1:0]      sp_d     [NUM_CH];
   logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
   logic [DATA_WIDTH-1:0] top_word [NUM_CH];
   logic [DATA_WIDTH-1:0] data_rd_q;
   logic [DATA_WIDTH-1:0] data_rd_d;
   logic [NUM_CH-1:0]     wr_go;
   logic [NUM_CH-1:0]     rd_go;
   logic                  bypass;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         top_word[c] = '0;
         for (int e = 0; e < DEPTH; e++) begin
            if (sp_q[c] == CNT_W'(e + 1)) begin
               top_word[c] = mem_q[c][e];
            end
         end
      end
   end

   always_comb begin
      bypass    = wr_en && rd_en && (wr_ch == rd_ch) && CH_VALID[wr_ch];
      data_rd_d = data_rd_q;
      wr_go     = '0;
      rd_go     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sp_d[c] = sp_q[c];
         if (!bypass && wr_en && (wr_ch == CH_W'(c)) && (sp_q[c] != CNT_W'(DEPTH))) begin
            wr_go[c] = 1'b1;
            sp_d[c]  = sp_q[c] + CNT_W'(1);
         end
         // A non-bypass pop can never share a channel with the push above.
         if (!bypass && rd_en && (rd_ch == CH_W'(c)) && (sp_q[c] != '0)) begin
            rd_go[c]  = 1'b1;
            sp_d[c]   = sp_q[c] - CNT_W'(1);
            data_rd_d = top_word[c];
         end
      end
      if (bypass) begin
         data_rd_d = data_wr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sp_q[c] <= '0;
         end
         data_rd_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            sp_q[c] <= sp_d[c];
         end
         data_rd_q <= data_rd_d;
      end
   end

   // Storage carries no reset; stale entries sit above sp and are never observed.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (wr_go[c] && (sp_q[c] == CNT_W'(e))) begin
               mem_q[c][e] <= data_wr;
            end
         end
      end
   end

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_status
         assign lifo_full[c]                = (sp_q[c] == CNT_W'(DEPTH));
         assign lifo_empty[c]               = (sp_q[c] == '0);
         assign count[c*CNT_W +: CNT_W]     = sp_q[c];
      end
   endgenerate

   assign data_rd = data_rd_q;

`ifdef LIFO_ERR_FLAG_EN
   logic wr_err_q;
   logic wr_err_d;
   logic rd_err_q;
   logic rd_err_d;

   // Any request that neither bypassed nor moved a pointer was dropped.
   always_comb begin
      wr_err_d = wr_en && !bypass && (wr_go == '0);
      rd_err_d = rd_en && !bypass && (rd_go == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
         rd_err_q <= rd_err_d;
      end
   end

   assign wr_err = wr_err_q;
   assign rd_err = rd_err_q;
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lifo_multi_ch.sv
// Scoreboard bench for lifo_multi_ch: directed boundary cases plus random traffic
// checked against per-channel queue stacks.
//------------------------------------------------------------------------------
// Module   : tb_lifo_multi_ch
// Brief    : self-checking testbench for lifo_multi_ch (NUM_CH=2, DEPTH=4)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lifo_multi_ch;

   localparam int NUM_CH = 2;
   localparam int DEPTH  = 4;
   localparam int DW     = 8;
   localparam int CH_W   = 1;
   localparam int CNT_W  = 3;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [DW-1:0]           data_wr = '0;
   logic                    wr_en = 1'b0;
   logic [CH_W-1:0]         wr_ch = '0;
   logic                    rd_en = 1'b0;
   logic [CH_W-1:0]         rd_ch = '0;
   logic [DW-1:0]           data_rd;
   logic [NUM_CH-1:0]       lifo_full;
   logic [NUM_CH-1:0]       lifo_empty;
   logic [NUM_CH*CNT_W-1:0] count;
   logic                    wr_err;
   logic                    rd_err;

   always #5 clk = ~clk;

   lifo_multi_ch #(
      .NUM_CH    (NUM_CH),
      .DEPTH     (DEPTH),
      .DATA_WIDTH(DW)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .data_wr   (data_wr),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .rd_en     (rd_en),
      .rd_ch     (rd_ch),
      .data_rd   (data_rd),
      .lifo_full (lifo_full),
      .lifo_empty(lifo_empty),
      .count     (count),
      .wr_err    (wr_err),
      .rd_err    (rd_err)
   );

   typedef struct packed {
      logic [DW-1:0]           data;
      logic [NUM_CH*CNT_W-1:0] cnt;
      logic [NUM_CH-1:0]       full;
      logic [NUM_CH-1:0]       empty;
      logic                    werr;
      logic                    rerr;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] stk [NUM_CH][$];
   logic [DW-1:0] m_data = '0;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
   task automatic cycle(input logic w, input int wc, input logic [DW-1:0] d,
                        input logic r, input int rc);
      exp_t rec;
      logic e_werr;
      logic e_rerr;
      @(negedge clk);
      wr_en   = w;
      wr_ch   = wc[0];
      data_wr = d;
      rd_en   = r;
      rd_ch   = rc[0];
      @(posedge clk);
      e_werr = 1'b0;
      e_rerr = 1'b0;
      if (w && r && (wc == rc)) begin
         m_data = d;
      end else begin
         if (r) begin
            if (stk[rc].size() > 0) m_data = stk[rc].pop_back();
            else                    e_rerr = 1'b1;
         end
         if (w) begin
            if (stk[wc].size() < DEPTH) stk[wc].push_back(d);
            else                        e_werr = 1'b1;
         end
      end
      rec.data = m_data;
      for (int c = 0; c < NUM_CH; c++) begin
         rec.cnt[c*CNT_W +: CNT_W] = CNT_W'(stk[c].size());
         rec.full[c]  = (stk[c].size() == DEPTH);
         rec.empty[c] = (stk[c].size() == 0);
      end
`ifdef LIFO_ERR_FLAG_EN
      rec.werr = e_werr;
      rec.rerr = e_rerr;
`else
      rec.werr = 1'b0;
      rec.rerr = 1'b0;
`endif
      exp_q.push_back(rec);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_rd"}, data_rd, 0);
      check({tag, "_count"}, count, 0);
      check({tag, "_empty"}, lifo_empty, 2'b11);
      check({tag, "_full"}, lifo_full, 0);
      check({tag, "_wr_err"}, wr_err, 0);
      check({tag, "_rd_err"}, rd_err, 0);
   endtask

   // Asserts reset between edges and checks outputs before any clock edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2 rst = 1'b0;
      #1 check_reset_outputs(tag);
      for (int c = 0; c < NUM_CH; c++) stk[c].delete();
      m_data = '0;
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t rec;
      if (exp_q.size() > 0) begin
         rec = exp_q.pop_front();
         check("data_rd", data_rd, rec.data);
         check("count", count, rec.cnt);
         check("lifo_full", lifo_full, rec.full);
         check("lifo_empty", lifo_empty, rec.empty);
         check("wr_err", wr_err, rec.werr);
         check("rd_err", rd_err, rec.rerr);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // Basic LIFO order on ch0
      cycle(1, 0, 8'h11, 0, 0);
      cycle(1, 0, 8'h22, 0, 0);
      cycle(1, 0, 8'h33, 0, 0);
      repeat (3) cycle(0, 0, 8'h00, 1, 0);

      // Full boundary on ch1: fifth push dropped
      for (int i = 0; i < 5; i++) cycle(1, 1, 8'hA0 + 8'(i), 0, 0);
      repeat (4) cycle(0, 0, 8'h00, 1, 1);

      // Empty boundary on ch0
      cycle(0, 0, 8'h00, 1, 0);
      cycle(0, 0, 8'h00, 0, 0);

      // Same-channel bypass, partial then empty
      cycle(1, 0, 8'h05, 0, 0);
      cycle(1, 0, 8'h77, 1, 0);
      cycle(0, 0, 8'h00, 1, 0);
      cycle(1, 1, 8'h5A, 1, 1);

      // Bypass on a full stack
      for (int i = 0; i < 4; i++) cycle(1, 1, 8'hB0 + 8'(i), 0, 0);
      cycle(1, 1, 8'hEE, 1, 1);
      repeat (4) cycle(0, 0, 8'h00, 1, 1);

      // Cross-channel concurrency
      cycle(1, 0, 8'h10, 0, 0);
      cycle(1, 0, 8'h20, 0, 0);
      cycle(1, 1, 8'h99, 1, 0);
      cycle(1, 0, 8'h44, 1, 1);

      // Random mixed traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end
      cycle(0, 0, 8'h00, 0, 0);

      // Asynchronous reset with ch0 at three entries
      async_reset("clear");
      for (int i = 0; i < 4; i++) cycle(1, 0, 8'hC1 + 8'(i), 0, 0);
      cycle(0, 0, 8'h00, 1, 0);
      async_reset("midstream");

      // Restart from empty
      cycle(0, 0, 8'h00, 1, 0);
      cycle(1, 0, 8'h3C, 0, 0);
      cycle(0, 0, 8'h00, 1, 0);
      cycle(0, 0, 8'h00, 0, 0);

      repeat (2) @(negedge clk);
      #1 check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
